echo_ranger: RTL
================

# echo_ranger

Receive-side counterpart to the ultrasonic burst generator. Measures time-of-flight from the start of each transmit burst window to the first qualified echo from the receiver comparator, in centimetre ticks: 1 cm range equals 1/17000 s round trip. Produces a registered distance with a valid strobe, or a timeout strobe. Sits between the analog receiver front end and the display/BCD path, all in the `system_clk` (100 MHz) domain.

## Interface
- `CM_DIV`, 5882: `system_clk` cycles per 1 cm range tick (100 MHz / 17 kHz).
- `BLANK_CM`, 5: ticks after burst start during which echo is ignored (transducer ringing).
- `MAX_CM`, 400: tick count at which the measurement times out.
- `ECHO_MIN`, 8: consecutive high synchronized samples required to qualify an echo.
- `DIST_W`, 10: width of the distance output.

Ports:
- `system_clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `burst_gate`  in  1  burst window level from the generator. Derived-clock domain, so treated as asynchronous. Its rising edge starts a measurement.
- `echo_in`  in  1  receiver comparator output, asynchronous, high = echo energy.
- `distance_cm`  out  DIST_W  last qualified distance in cm.
- `dist_valid`  out  1  one-cycle strobe when `distance_cm` updates.
- `timeout`  out  1  one-cycle strobe when a measurement reaches MAX_CM with no echo.
- `busy`  out  1  high while in BLANK or LISTEN.

## Operation
- Synchronization:
  - `burst_gate` and `echo_in` each pass through a 2-flop synchronizer, plus one history flop for edge detection.
  - Both paths have identical latency, so the input-to-input offset equals the measured offset.
- Tick counters:
  - `pre_cnt` runs 0..CM_DIV-1.
  - On wrap, `cm_cnt` increments; `cm_cnt` saturates at MAX_CM.
  - Both counters clear on a detected burst edge.
- FSM states: IDLE, BLANK, LISTEN.
  - IDLE: counters held at 0. Burst rising edge → BLANK.
  - BLANK: counters run; echo ignored and the run counter held at 0. When `cm_cnt` == BLANK_CM → LISTEN.
  - LISTEN:
    - On an `echo_s` 0→1 edge (or `echo_s` already high on entry), latch `cm_cnt` into `cand` and start the run counter at 1.
    - The run counter increments while `echo_s` is high and clears when it is low.
    - Run counter reaching ECHO_MIN → `distance_cm` <= `cand`, `dist_valid` = 1 next cycle, → IDLE.
    - `cm_cnt` reaching MAX_CM without qualification → `timeout` = 1 next cycle, `distance_cm` unchanged, → IDLE.
- Priorities and boundaries:
  - Qualification and MAX_CM in the same cycle: qualification wins, and no timeout is issued.
  - Burst edge while in BLANK or LISTEN: the measurement aborts silently (no strobe), counters clear, → BLANK.
  - Burst edge in the same cycle as a qualification: `dist_valid` is still issued for the old measurement, and the FSM goes to BLANK for the new one.
  - Echo pulses shorter than ECHO_MIN are discarded; a later rise re-latches `cand`.
  - `distance_cm` is the low DIST_W bits of `cand`. MAX_CM must be < 2^DIST_W.

## Timing
- Reset values: `distance_cm` = 0, `dist_valid` = 0, `timeout` = 0, `busy` = 0. All synchronizer, history and counter flops = 0. FSM = IDLE.
- Burst edge on `burst_gate` → state BLANK and `busy` = 1 three `system_clk` edges later.
- Qualification: the `dist_valid` rise occurs on the edge after the run counter reaches ECHO_MIN, i.e. ECHO_MIN+3 edges after the `echo_in` rise.
- The `busy` fall coincides with the cycle `dist_valid` or `timeout` is high.
- `dist_valid` and `timeout` are never high together, and each is high for exactly one cycle.
- Resolution is 1 cm and truncating: the echo is reported as floor(cycles/CM_DIV).

## Test plan
Bench parameters: CM_DIV=10, BLANK_CM=2, MAX_CM=50, ECHO_MIN=4, DIST_W=10.

1. Reset mid-LISTEN.
   - Stimulus: assert `reset` 100 cycles after a burst edge.
   - Required: all outputs 0 immediately; no strobe after release.
2. Nominal echo.
   - Stimulus: `echo_in` rises 237 cycles after the `burst_gate` rise and holds 20 cycles.
   - Required: `distance_cm` = 23, a single `dist_valid` pulse, `busy` falls the same cycle.
3. Blanking and glitch rejection.
   - Stimulus: echo high at offset 5–15 (inside blank), glitch 3 cycles at offset 100, real echo at offset 412.
   - Required: `distance_cm` = 41, exactly one `dist_valid`.
4. Timeout.
   - Stimulus: no echo after the burst.
   - Required: `timeout` pulse at ~500+3 cycles, `distance_cm` keeps its prior value 41, no `dist_valid`.
5. Burst restart.
   - Stimulus: second burst edge at offset 300, then echo 150 cycles after the second edge.
   - Required: no strobe for the first burst; `distance_cm` = 15.
6. Boundary.
   - Stimulus: echo qualifies on the same cycle `cm_cnt` reaches 50.
   - Required: `dist_valid` with `distance_cm` = 49, no `timeout`.

Source files
------------

// File: rtl/echo_ranger.sv
// Ultrasonic echo ranger: measures time-of-flight from each burst-window rise to the
// first qualified echo, reported in 1 cm range ticks with a valid or timeout strobe.
module echo_ranger #(
  parameter int unsigned CM_DIV   = 5882,
  parameter int unsigned BLANK_CM = 5,
  parameter int unsigned MAX_CM   = 400,
  parameter int unsigned ECHO_MIN = 8,
  parameter int unsigned DIST_W   = 10
) (
  input  logic              system_clk,
  input  logic              reset,
  input  logic              burst_gate,
  input  logic              echo_in,
  output logic [DIST_W-1:0] distance_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic              busy
);

  localparam int unsigned PRE_W = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;
  localparam int unsigned CM_W  = $clog2(MAX_CM + 1);
  localparam int unsigned RUN_W = $clog2(ECHO_MIN + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_LISTEN = 2'd2
  } state_t;

  logic              r_burst_s1, r_burst_s2, r_burst_h;
  logic              r_echo_s1, r_echo_s2, r_echo_h;
  state_t            r_state, w_state_nxt;
  logic [PRE_W-1:0]  r_pre, w_pre_nxt, w_pre_inc;
  logic [CM_W-1:0]   r_cm, w_cm_nxt, w_cm_inc;
  logic [CM_W-1:0]   r_cand, w_cand_nxt;
  logic [RUN_W-1:0]  r_run, w_run_nxt;
  logic [DIST_W-1:0] r_distance, w_distance_nxt;
  logic              r_dist_valid, w_dist_valid_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic              r_busy;
  logic              w_burst_rise, w_echo_start, w_tick;

  // Both inputs see identical synchronizer latency, so offsets are preserved
  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      r_burst_s1 <= 1'b0;
      r_burst_s2 <= 1'b0;
      r_burst_h  <= 1'b0;
      r_echo_s1  <= 1'b0;
      r_echo_s2  <= 1'b0;
      r_echo_h   <= 1'b0;
    end else begin
      r_burst_s1 <= burst_gate;
      r_burst_s2 <= r_burst_s1;
      r_burst_h  <= r_burst_s2;
      r_echo_s1  <= echo_in;
      r_echo_s2  <= r_echo_s1;
      r_echo_h   <= r_echo_s2;
    end
  end

  assign w_burst_rise = r_burst_s2 & ~r_burst_h;
  // run == 0 with echo high also catches an echo already present on LISTEN entry
  assign w_echo_start = r_echo_s2 & (~r_echo_h | (r_run == '0));
  assign w_tick       = (r_pre == PRE_W'(CM_DIV - 1));
  assign w_pre_inc    = w_tick ? '0 : PRE_W'(r_pre + 1'b1);
  assign w_cm_inc     = (w_tick && (r_cm != CM_W'(MAX_CM))) ? CM_W'(r_cm + 1'b1) : r_cm;

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pre        <= '0;
      r_cm         <= '0;
      r_cand       <= '0;
      r_run        <= '0;
      r_distance   <= '0;
      r_dist_valid <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pre        <= w_pre_nxt;
      r_cm         <= w_cm_nxt;
      r_cand       <= w_cand_nxt;
      r_run        <= w_run_nxt;
      r_distance   <= w_distance_nxt;
      r_dist_valid <= w_dist_valid_nxt;
      r_timeout    <= w_timeout_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pre_nxt        = r_pre;
    w_cm_nxt         = r_cm;
    w_cand_nxt       = r_cand;
    w_run_nxt        = r_run;
    w_distance_nxt   = r_distance;
    w_dist_valid_nxt = 1'b0;
    w_timeout_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_pre_nxt = '0;
        w_cm_nxt  = '0;
        w_run_nxt = '0;
      end
      S_BLANK: begin
        w_pre_nxt = w_pre_inc;
        w_cm_nxt  = w_cm_inc;
        w_run_nxt = '0;
        if (r_cm == CM_W'(BLANK_CM)) begin
          w_state_nxt = S_LISTEN;
        end
      end
      S_LISTEN: begin
        w_pre_nxt = w_pre_inc;
        w_cm_nxt  = w_cm_inc;
        if (w_echo_start) begin
          w_cand_nxt = r_cm;
          w_run_nxt  = RUN_W'(1);
        end else if (r_echo_s2) begin
          w_run_nxt = RUN_W'(r_run + 1'b1);
        end else begin
          w_run_nxt = '0;
        end
        // Qualification outranks a simultaneous MAX_CM timeout
        if (r_run == RUN_W'(ECHO_MIN)) begin
          w_distance_nxt   = DIST_W'(r_cand);
          w_dist_valid_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end else if (r_cm == CM_W'(MAX_CM)) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // A new burst restarts timing; the edge cycle itself counts as the first tick
    if (w_burst_rise) begin
      w_state_nxt   = S_BLANK;
      w_pre_nxt     = PRE_W'(1);
      w_cm_nxt      = '0;
      w_run_nxt     = '0;
      w_timeout_nxt = 1'b0;
    end
  end

  assign distance_cm = r_distance;
  assign dist_valid  = r_dist_valid;
  assign timeout     = r_timeout;
  assign busy        = r_busy;

endmodule
